pheap_level_ctrl: RTL
=====================

PHEAP_LEVEL_CTRL -- requirements
Module: pheap_level_ctrl

Interface
REQ-001 SHALL have parameter LEVELS, default 4: heap depth; width of the entry capacity field.
REQ-002 SHALL have parameter ADDR_W, default 1: node index width of this level.
REQ-003 SHALL have parameter LAST_LEVEL, default 0: 1 means no downstream level exists.
REQ-004 SHALL use an entry packing of {value[31:0], cap[LEVELS-1:0], active}; ENTRY_W = 33+LEVELS.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have these ports:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  up_valid  in  1  operation request from level above
  up_ready  out  1  controller can accept an operation
  up_op  in  1  0=insert, 1=pop
  up_addr  in  ADDR_W  node index at this level
  up_value  in  32  insert value
  pop_valid  out  1  one-cycle pop result strobe to level above
  pop_value  out  32  popped value
  pop_empty  out  1  with pop_valid: node was inactive
  mem_raddr  out  ADDR_W  level memory read address
  mem_rdata  in  ENTRY_W  level memory read data, registered, 1-cycle latency
  mem_wen  out  1  level memory write enable
  mem_wraddr  out  ADDR_W  level memory write address
  mem_wdata  out  ENTRY_W  level memory write data
  dn_valid, dn_ready  out/in  1  downstream request handshake
  dn_op  out  1  0=insert, 1=pop
  dn_addr  out  ADDR_W+1  child index {addr, sel}
  dn_value  out  32  downstream insert value
  dn_ret_valid  in  1  replacement returned by downstream pop
  dn_ret_value  in  32  replacement value
  dn_ret_empty  in  1  downstream subtree empty
  full_err  out  1  one-cycle strobe: insert dropped

Function
REQ-007 SHALL implement FSM states IDLE, READ, EVAL, FWD, WAIT_RET.
REQ-008 SHALL assert up_ready only in IDLE; transfer occurs on up_valid&&up_ready; op, addr, value latched.
REQ-009 SHALL go IDLE->READ on transfer; READ drives mem_raddr=latched addr; READ->EVAL next cycle.
REQ-010 SHALL treat mem_rdata as entry e only in EVAL; mem_wen SHALL be asserted at most one cycle per operation.
REQ-011 Insert, e.active=0: write {value, e.cap, 1}, no downstream request, EVAL->IDLE.
REQ-012 Insert, e.active=1, e.cap!=0, LAST_LEVEL=0: write {min(value,e.value), e.cap-1, 1}; dn_op=0, dn_value=max, dn_addr={addr,e.cap[0]}; EVAL->FWD.
REQ-013 Insert, e.active=1 and (e.cap==0 or LAST_LEVEL=1): no write, no dn request, full_err pulses one cycle in EVAL, EVAL->IDLE.
REQ-014 Values compared unsigned 32-bit; equal values keep the incoming value in the node.
REQ-015 Pop, e.active=0: pop_valid=1, pop_empty=1, pop_value=0, no write, EVAL->IDLE.
REQ-016 Pop, e.active=1: pop_valid=1, pop_value=e.value, pop_empty=0 in EVAL; if LAST_LEVEL=1 write {0, e.cap, 0}, ->IDLE; else dn_op=1, dn_addr={addr,1'b0}, EVAL->FWD.
REQ-017 FWD SHALL hold dn_valid=1 with dn_op/addr/value stable until dn_ready; insert ->IDLE, pop ->WAIT_RET.
REQ-018 WAIT_RET on dn_ret_valid: dn_ret_empty=0 writes {dn_ret_value, e.cap+1, 1}; dn_ret_empty=1 writes {0, e.cap+1, 0}; ->IDLE.
REQ-019 e.cap+1 SHALL saturate at all-ones.
REQ-020 dn_ret_valid outside WAIT_RET SHALL be ignored.
REQ-021 mem_wraddr SHALL equal latched addr whenever mem_wen=1.

Reset
REQ-022 rst_n low SHALL force IDLE and drive up_ready=1 and every other output to 0, including mid-operation; no write is completed.
REQ-023 Latched op/addr/value/entry registers SHALL reset to 0.

Configuration
REQ-024 With PHEAP_FASTREAD_EN defined: mem_raddr=up_addr combinationally in the transfer cycle and IDLE->EVAL directly; READ unused; insert-without-forward completes 1 cycle sooner.
REQ-025 Without PHEAP_FASTREAD_EN: READ state used as in REQ-009; mem_raddr registered.

Verification
REQ-026 LEVELS=4: insert 5 at addr 0, rdata inactive cap=4'hF -> one mem_wen, wdata {5,4'hF,1}, dn_valid never 1, up_ready high 3 cycles after transfer (2 with macro).
REQ-027 Insert 3, rdata {7,cap=3,1} -> wdata {3,2,1}; dn_op=0, dn_value=7, dn_addr=2'b01.
REQ-028 Insert 8, rdata {4,cap=0,1} -> full_err one cycle, mem_wen and dn_valid stay 0.
REQ-029 Pop, rdata {9,2,1} -> pop_valid with 9; dn pop; ret 12 not empty -> wdata {12,3,1}; rerun with ret empty -> wdata {0,3,0}.
REQ-030 Insert forwarding with dn_ready low 5 cycles -> dn_valid and dn_value/dn_addr stable all 5 cycles, IDLE 1 cycle after dn_ready.
REQ-031 rst_n low during WAIT_RET -> IDLE, all outputs 0, up_ready=1, no mem_wen; later dn_ret_valid ignored.

Source files
------------

// File: rtl/pheap_level_ctrl.sv
// One level of a pipelined binary heap: reads a node, decides keep/forward/drop, and talks to the level below.
// Optional: define PHEAP_FASTREAD_EN to issue the node read in the transfer cycle and skip READ.
module pheap_level_ctrl #(
    parameter int  LEVELS     = 4,
    parameter int  ADDR_W     = 1,
    parameter int  LAST_LEVEL = 0,
    localparam int ENTRY_W    = 33 + LEVELS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic               up_op,
    input  logic [ADDR_W-1:0]  up_addr,
    input  logic [31:0]        up_value,
    output logic               pop_valid,
    output logic [31:0]        pop_value,
    output logic               pop_empty,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [ENTRY_W-1:0] mem_rdata,
    output logic               mem_wen,
    output logic [ADDR_W-1:0]  mem_wraddr,
    output logic [ENTRY_W-1:0] mem_wdata,
    output logic               dn_valid,
    input  logic               dn_ready,
    output logic               dn_op,
    output logic [ADDR_W:0]    dn_addr,
    output logic [31:0]        dn_value,
    input  logic               dn_ret_valid,
    input  logic [31:0]        dn_ret_value,
    input  logic               dn_ret_empty,
    output logic               full_err
);

    typedef struct packed {
        logic [31:0]       value;
        logic [LEVELS-1:0] cap;
        logic              active;
    } entry_t;

    typedef enum logic [2:0] {IDLE, READ, EVAL, FWD, WAIT_RET} state_t;

    localparam bit HAS_DN = (LAST_LEVEL == 0);

    state_t state, next_state;

    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       value_q;
    logic [LEVELS-1:0] cap_q;
    logic              dn_op_q;
    logic [ADDR_W:0]   dn_addr_q;
    logic [31:0]       dn_value_q;

    entry_t            e, wr;
    logic              keep_in, dn_load;
    logic [31:0]       lo, hi;
    logic [LEVELS-1:0] cap_inc;
    logic [ADDR_W:0]   dn_addr_n;
    logic [31:0]       dn_value_n;

    assign e       = mem_rdata;
    // Ties keep the incoming value in the node and push the resident one down.
    assign keep_in = (value_q <= e.value);
    assign lo      = keep_in ? value_q : e.value;
    assign hi      = keep_in ? e.value : value_q;
    assign cap_inc = (&cap_q) ? cap_q : cap_q + LEVELS'(1);

    assign dn_addr_n  = op_q ? {addr_q, 1'b0} : {addr_q, e.cap[0]};
    assign dn_value_n = op_q ? 32'd0 : hi;

`ifdef PHEAP_FASTREAD_EN
    assign mem_raddr = (rst_n && state == IDLE && up_valid) ? up_addr : '0;
`else
    assign mem_raddr = (state == READ) ? addr_q : '0;
`endif

    assign mem_wdata  = wr;
    assign mem_wraddr = mem_wen ? addr_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        up_ready   = 1'b0;
        pop_valid  = 1'b0;
        pop_value  = '0;
        pop_empty  = 1'b0;
        mem_wen    = 1'b0;
        wr         = '0;
        full_err   = 1'b0;
        dn_valid   = 1'b0;
        dn_op      = 1'b0;
        dn_addr    = '0;
        dn_value   = '0;
        dn_load    = 1'b0;
        case (state)
            IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
`ifdef PHEAP_FASTREAD_EN
                    next_state = EVAL;
`else
                    next_state = READ;
`endif
                end
            end
            READ: next_state = EVAL;
            EVAL: begin
                next_state = IDLE;
                if (!op_q) begin
                    if (!e.active) begin
                        mem_wen = 1'b1;
                        wr      = '{value: value_q, cap: e.cap, active: 1'b1};
                    end else if (e.cap != '0 && HAS_DN) begin
                        mem_wen    = 1'b1;
                        wr         = '{value: lo, cap: e.cap - LEVELS'(1), active: 1'b1};
                        dn_load    = 1'b1;
                        next_state = FWD;
                    end else begin
                        full_err = 1'b1;
                    end
                end else begin
                    pop_valid = 1'b1;
                    if (!e.active) begin
                        pop_empty = 1'b1;
                    end else begin
                        pop_value = e.value;
                        if (HAS_DN) begin
                            dn_load    = 1'b1;
                            next_state = FWD;
                        end else begin
                            mem_wen = 1'b1;
                            wr      = '{value: 32'd0, cap: e.cap, active: 1'b0};
                        end
                    end
                end
            end
            FWD: begin
                dn_valid = 1'b1;
                dn_op    = dn_op_q;
                dn_addr  = dn_addr_q;
                dn_value = dn_value_q;
                if (dn_ready) next_state = op_q ? WAIT_RET : IDLE;
            end
            WAIT_RET: begin
                if (dn_ret_valid) begin
                    mem_wen    = 1'b1;
                    wr         = dn_ret_empty ? '{value: 32'd0, cap: cap_inc, active: 1'b0}
                                              : '{value: dn_ret_value, cap: cap_inc, active: 1'b1};
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 1'b0;
            addr_q     <= '0;
            value_q    <= '0;
            cap_q      <= '0;
            dn_op_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_value_q <= '0;
        end else begin
            if (state == IDLE && up_valid) begin
                op_q    <= up_op;
                addr_q  <= up_addr;
                value_q <= up_value;
            end
            // Capacity is needed again when the pop replacement returns.
            if (state == EVAL) cap_q <= e.cap;
            if (dn_load) begin
                dn_op_q    <= op_q;
                dn_addr_q  <= dn_addr_n;
                dn_value_q <= dn_value_n;
            end
        end
    end

endmodule
